// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package imem_loader_pkg;

  localparam int unsigned WORD_W         = 32;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned BYTES_PER_WORD = WORD_W / BYTE_W;
  localparam int unsigned BYTE_IDX_W     = $clog2(BYTES_PER_WORD);

  localparam logic [WORD_W-1:0] TERM_WORD = 32'h0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_LOAD,
    ST_WRITE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: byte k of a word lands in bits [8k+7:8k].
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              accept,
  input  logic              clear,
  input  logic [BYTE_W-1:0] byte_data,
  output logic              last_c,
  output logic              word_valid,
  output logic [WORD_W-1:0] word_o
);

  logic [BYTE_IDX_W-1:0] cnt;

  assign last_c = (cnt == BYTE_IDX_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      word_o     <= '0;
      cnt        <= '0;
      word_valid <= 1'b0;
    end else if (accept) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        if (cnt == BYTE_IDX_W'(k)) word_o[BYTE_W*k +: BYTE_W] <= byte_data;
      end
      cnt        <= cnt + BYTE_IDX_W'(1);
      word_valid <= last_c;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Streams a program into instruction memory and holds the CPU in reset until done.
// Optional IMEM_LOADER_CLEAR_EN zeroes the whole memory before every load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              s_valid_i,
  input  logic [BYTE_W-1:0] s_data_i,
  output logic              s_ready_o,
  output logic              im_we_o,
  output logic [ADDR_W-1:0] im_addr_o,
  output logic [WORD_W-1:0] im_wdata_o,
  output logic              cpu_rst_n_o,
  output logic              done_o,
  output logic [ADDR_W:0]   word_cnt_o
);

  localparam int unsigned CNT_W = ADDR_W + 1;

`ifdef IMEM_LOADER_CLEAR_EN
  localparam state_t LOAD_ENTRY = ST_CLEAR;
`else
  localparam state_t LOAD_ENTRY = ST_LOAD;
`endif

  state_t state, state_next;
  logic   ready_d, we_d, done_d;
  logic   accept, start_take, ptr_last, last_c, word_valid;

  assign accept     = s_valid_i && s_ready_o;
  assign start_take = start_i && ((state == ST_IDLE) || (state == ST_DONE));
  assign ptr_last   = (im_addr_o == ADDR_W'(DEPTH - 1));

  // Packer output is the write-data register; it is cleared on start and after each WRITE.
  byte_packer u_packer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .accept     (accept),
    .clear      (start_take || (state == ST_WRITE)),
    .byte_data  (s_data_i),
    .last_c     (last_c),
    .word_valid (word_valid),
    .word_o     (im_wdata_o)
  );

  // State register; the control outputs are registered decodes of the next state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= ST_IDLE;
      s_ready_o   <= 1'b0;
      im_we_o     <= 1'b0;
      done_o      <= 1'b0;
      cpu_rst_n_o <= 1'b0;
    end else begin
      state       <= state_next;
      s_ready_o   <= ready_d;
      im_we_o     <= we_d;
      done_o      <= done_d;
      cpu_rst_n_o <= done_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (start_i) state_next = LOAD_ENTRY;
      ST_CLEAR: if (ptr_last) state_next = ST_LOAD;
      ST_LOAD:  if (accept && last_c) state_next = ST_WRITE;
      ST_WRITE: if (word_valid) begin
        state_next = ((im_wdata_o == TERM_WORD) || ptr_last) ? ST_DONE : ST_LOAD;
      end
      ST_DONE:  if (start_i) state_next = LOAD_ENTRY;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    ready_d = 1'b0;
    we_d    = 1'b0;
    done_d  = 1'b0;
    case (state_next)
      ST_CLEAR: we_d    = 1'b1;
      ST_LOAD:  ready_d = 1'b1;
      ST_WRITE: we_d    = 1'b1;
      ST_DONE:  done_d  = 1'b1;
      default:  ;
    endcase
  end

  // Write pointer doubles as the address output; it stops at DEPTH-1 instead of wrapping.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_take) begin
      im_addr_o  <= '0;
      word_cnt_o <= '0;
    end else begin
      case (state)
        ST_CLEAR: im_addr_o <= ptr_last ? '0 : im_addr_o + ADDR_W'(1);
        ST_WRITE: begin
          if (!ptr_last) im_addr_o <= im_addr_o + ADDR_W'(1);
          if (word_cnt_o != CNT_W'(DEPTH)) word_cnt_o <= word_cnt_o + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader; models the instruction memory from the write port.
module tb_imem_loader;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
`ifdef IMEM_LOADER_CLEAR_EN
  localparam int          CLR_W   = DEPTH;
  localparam logic [31:0] TAIL_EXP = 32'h0;
`else
  localparam int          CLR_W   = 0;
  localparam logic [31:0] TAIL_EXP = 32'hFFFF_FFFF;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h0;
  logic              s_ready_o, im_we_o, cpu_rst_n_o, done_o;
  logic [ADDR_W-1:0] im_addr_o;
  logic [31:0]       im_wdata_o;
  logic [ADDR_W:0]   word_cnt_o;

  imem_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .start_i     (start),
    .s_valid_i   (s_valid),
    .s_data_i    (s_data),
    .s_ready_o   (s_ready_o),
    .im_we_o     (im_we_o),
    .im_addr_o   (im_addr_o),
    .im_wdata_o  (im_wdata_o),
    .cpu_rst_n_o (cpu_rst_n_o),
    .done_o      (done_o),
    .word_cnt_o  (word_cnt_o)
  );

  always #5 clk = ~clk;

  // Memory model and write log, sampled at the active edge.
  logic [31:0] mem [DEPTH];
  int          wr_addr_q[$];
  int          wr_total = 0, cyc = 0, last_wr_cyc = 0, rise_cyc = -1;
  logic        prev_rstn = 1'b0;
  logic        fill_req = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (fill_req) for (int i = 0; i < DEPTH; i++) mem[i] = 32'hFFFF_FFFF;
    if (im_we_o) begin
      mem[im_addr_o] = im_wdata_o;
      wr_total++;
      wr_addr_q.push_back(int'(im_addr_o));
      last_wr_cyc = cyc;
    end
    if (cpu_rst_n_o && !prev_rstn) rise_cyc = cyc;
    prev_rstn = cpu_rst_n_o;
  end

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          gap;
    int          exp_cnt;
  } vec_t;

  vec_t vecs[4];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_ready"}, 32'(s_ready_o), 32'd0);
    chk({tag, "_we"}, 32'(im_we_o), 32'd0);
    chk({tag, "_addr"}, 32'(im_addr_o), 32'd0);
    chk({tag, "_wdata"}, im_wdata_o, 32'd0);
    chk({tag, "_cpu_rst_n"}, 32'(cpu_rst_n_o), 32'd0);
    chk({tag, "_done"}, 32'(done_o), 32'd0);
    chk({tag, "_cnt"}, 32'(word_cnt_o), 32'd0);
  endtask

  task automatic start_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    if (CLR_W != 0) chk("start_first_clear_we", 32'(im_we_o), 32'd1);
    else chk("start_ready", 32'(s_ready_o), 32'd1);
    chk("start_cpu_rst_n_low", 32'(cpu_rst_n_o), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    s_valid = 1'b0;
    repeat (gap) tick();
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    while (!s_ready_o && n < 100) begin
      tick();
      n++;
    end
    if (!s_ready_o) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte %h not accepted within 100 cycles", b);
    end else begin
      tick();
    end
    s_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input int gap);
    for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done_o && n < 300) begin
      tick();
      n++;
    end
    if (!done_o) begin
      checks++;
      errors++;
      $display("FAIL %s_done_timeout: done_o still %b after 300 cycles", name, done_o);
    end
    tick();
  endtask

  initial begin
    int wr0;
    vecs[0] = '{w0: 32'h2000_0113, w1: 32'h0, gap: 0, exp_cnt: 2};
    vecs[1] = '{w0: 32'h2000_0113, w1: 32'h0, gap: 3, exp_cnt: 2};
    vecs[2] = '{w0: 32'h0,         w1: 32'h0, gap: 0, exp_cnt: 1};
    vecs[3] = '{w0: 32'hDEAD_BEEF, w1: 32'h0, gap: 1, exp_cnt: 2};

    repeat (2) tick();
    chk_reset("reset");
    rst = 1'b0;
    tick();

    // Program vectors; every run after the first starts from DONE.
    for (int i = 0; i < 4; i++) begin
      wr0 = wr_total;
      start_load();
      send_word(vecs[i].w0, vecs[i].gap);
      if (vecs[i].w0 != 32'h0) send_word(vecs[i].w1, vecs[i].gap);
      wait_done($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_word0", i), mem[0], vecs[i].w0);
      chk($sformatf("vec%0d_word1", i), mem[1], vecs[i].w1);
      chk($sformatf("vec%0d_cnt", i), 32'(word_cnt_o), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_writes", i), 32'(wr_total - wr0), 32'(vecs[i].exp_cnt + CLR_W));
      chk($sformatf("vec%0d_first_addr", i), 32'(wr_addr_q[wr0 + CLR_W]), 32'd0);
      chk($sformatf("vec%0d_release_cycle", i), 32'(rise_cyc), 32'(last_wr_cyc + 1));
      chk($sformatf("vec%0d_cpu_rst_n", i), 32'(cpu_rst_n_o), 32'd1);
    end

    // start_i in the middle of a word must not restart the load.
    start_load();
    send_byte(8'h0D, 0);
    send_byte(8'hF0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start_in_load_ready", 32'(s_ready_o), 32'd1);
    send_byte(8'hFE, 0);
    send_byte(8'hCA, 0);
    send_word(32'h0, 0);
    wait_done("start_in_load");
    chk("start_in_load_word0", mem[0], 32'hCAFE_F00D);
    chk("start_in_load_cnt", 32'(word_cnt_o), 32'd2);

    // Full memory with no terminator.
    wr0 = wr_total;
    start_load();
    for (int i = 0; i < DEPTH; i++) send_word(32'hA500_0000 | 32'(i + 1), 0);
    wait_done("full");
    chk("full_cnt", 32'(word_cnt_o), 32'(DEPTH));
    chk("full_writes", 32'(wr_total - wr0), 32'(DEPTH + CLR_W));
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("full_addr%0d", i), 32'(wr_addr_q[wr0 + CLR_W + i]), 32'(i));
      chk($sformatf("full_word%0d", i), mem[i], 32'hA500_0000 | 32'(i + 1));
    end
    wr0 = wr_total;
    s_valid = 1'b1;
    s_data  = 8'h55;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("full_after_ready%0d", i), 32'(s_ready_o), 32'd0);
      tick();
    end
    s_valid = 1'b0;
    chk("full_after_no_write", 32'(wr_total - wr0), 32'd0);
    chk("full_after_done", 32'(done_o), 32'd1);

    // Reset two bytes into word 1, then reload from address 0.
    start_load();
    send_word(32'h1122_3344, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    rst = 1'b1;
    tick();
    chk_reset("midreset");
    rst = 1'b0;
    tick();
    chk("midreset_word0_kept", mem[0], 32'h1122_3344);
    wr0 = wr_total;
    start_load();
    send_word(32'h0000_00AA, 0);
    send_word(32'h0, 0);
    wait_done("restart");
    chk("restart_first_addr", 32'(wr_addr_q[wr0 + CLR_W]), 32'd0);
    chk("restart_word0", mem[0], 32'h0000_00AA);
    chk("restart_cnt", 32'(word_cnt_o), 32'd2);

    // Reset and start together: reset wins and no load begins.
    rst   = 1'b1;
    start = 1'b1;
    tick();
    rst   = 1'b0;
    start = 1'b0;
    chk_reset("rst_start");
    tick();
    chk("rst_start_idle_ready", 32'(s_ready_o), 32'd0);
    chk("rst_start_idle_we", 32'(im_we_o), 32'd0);

    // Prefilled memory: words past the terminator are zeroed only by the clear phase.
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    start_load();
    send_word(32'h0000_0013, 0);
    send_word(32'h0, 0);
    wait_done("prefill");
    chk("prefill_word0", mem[0], 32'h0000_0013);
    chk("prefill_word1", mem[1], 32'h0);
    for (int i = 2; i < DEPTH; i++) chk($sformatf("prefill_tail%0d", i), mem[i], TAIL_EXP);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Streaming program loader that fills the pipeline CPU's instruction memory and holds the CPU in reset until the program is in place. It writes the instruction memory that the CPU fetch stage reads. Bytes arrive on a valid/ready byte stream and are packed little-endian into 32-bit words. Loading ends on the first all-zero word or when the memory is full; the loader then releases the CPU reset.

## Interface
- `DEPTH`, 32: instruction memory size in 32-bit words.
- `ADDR_W`, 5: word-address width; must satisfy 2^ADDR_W ≥ DEPTH.
- `clk_i` in 1: the single clock; all state changes on rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `start_i` in 1: one-cycle request to begin a load; honoured only in IDLE or DONE.
- `s_valid_i` in 1: byte stream valid.
- `s_data_i` in 8: byte stream data.
- `s_ready_o` out 1: loader accepts a byte this cycle.
- `im_we_o` out 1: instruction memory write enable.
- `im_addr_o` out ADDR_W: word index written.
- `im_wdata_o` out 32: word written.
- `cpu_rst_n_o` out 1: CPU reset, active-low; low while loading.
- `done_o` out 1: high in DONE.
- `word_cnt_o` out ADDR_W+1: words loaded, including the terminating zero word.

## Operation
- States:
  - IDLE: entered from reset.
  - CLEAR: present only with the macro below.
  - LOAD: assemble one word from the byte stream.
  - WRITE: write the assembled word.
  - DONE: program loaded; CPU released.
- IDLE + `start_i` goes to CLEAR, or to LOAD when the macro is not defined. `word_cnt_o` is set to 0 and the write pointer to 0.
- CLEAR: one word per cycle, `im_we_o`=1, `im_wdata_o`=0, addresses 0..DEPTH-1. After address DEPTH-1, go to LOAD with the pointer back at 0.
- LOAD:
  - `s_ready_o`=1.
  - A byte is accepted when `s_valid_i` and `s_ready_o` are both high.
  - Byte k (0..3) goes to bits [8k+7:8k].
  - When the 4th byte is accepted, go to WRITE.
- WRITE:
  - `s_ready_o`=0, `im_we_o`=1, address = pointer, data = assembled word.
  - Increment the pointer and `word_cnt_o`.
  - If the word == 0, or pointer == DEPTH-1, go to DONE.
  - Otherwise go back to LOAD with the byte counter cleared.
- DONE: `s_ready_o`=0, `done_o`=1, `cpu_rst_n_o`=1. `start_i` drives `cpu_rst_n_o` low and begins a new load exactly as from IDLE.
- `start_i` in CLEAR, LOAD or WRITE is ignored.
- A zero word is always written to memory before DONE, so fetch past the program end sees 0.
- Full memory (DEPTH words without a zero word) ends in DONE. Bytes offered afterwards are not accepted.
- Arithmetic: the pointer is ADDR_W bits and never wraps, because DONE is forced at DEPTH-1. `word_cnt_o` saturates at DEPTH.

## Timing
- All outputs are registered.
- Reset values:
  - `s_ready_o`=0, `im_we_o`=0, `im_addr_o`=0, `im_wdata_o`=0.
  - `cpu_rst_n_o`=0, `done_o`=0, `word_cnt_o`=0.
  - State IDLE; byte counter 0.
- The `start_i` edge is followed by the first CLEAR write, or by `s_ready_o`=1, in the next cycle.
- A full LOAD+WRITE takes at least 5 cycles per word: 4 accepted bytes, then 1 WRITE cycle.
- Bubbles on `s_valid_i` stall the byte counter; there is no timeout.
- `cpu_rst_n_o` rises in the same cycle `done_o` rises, which is the cycle after the final WRITE. The final write is therefore complete before the CPU leaves reset.
- `rst_i` mid-load aborts immediately. The partial word is discarded, memory contents written so far are left as-is, and `cpu_rst_n_o` returns to 0.
- `rst_i` and `start_i` high in the same cycle: reset wins.

## Configuration
- `IMEM_LOADER_CLEAR_EN`
  - Defined: the CLEAR phase zeroes all DEPTH words before every load, adding DEPTH cycles of latency.
  - Undefined: CLEAR is absent and words beyond the terminator keep their old contents.

## Structure
- A shared package holds:
  - the state enum (IDLE, CLEAR, LOAD, WRITE, DONE);
  - the word width (32);
  - the terminator value (32'h0).
- One sub-module, `byte_packer`: a 4-byte little-endian shift/assemble unit with accept, clear, word_valid and word_o ports.
- The top level holds the FSM, pointer and counters.

## Test plan
- Program 0x2000_0113, 0x0000_0000 sent as bytes 13 01 00 20 00 00 00 00 ->
  - word 0 = 0x20000113 and word 1 = 0;
  - `word_cnt_o`=2;
  - `cpu_rst_n_o` rises one cycle after the 2nd write.
- Same program, with `s_valid_i` deasserted for 3 cycles between every byte -> identical memory contents and `word_cnt_o`=2, with no extra writes.
- 32 nonzero words (DEPTH=32), no terminator ->
  - 32 writes at addresses 0..31;
  - DONE after address 31;
  - `word_cnt_o`=32;
  - the next offered byte sees `s_ready_o`=0.
- `rst_i` pulsed after 2 bytes of word 1 ->
  - all outputs return to reset values;
  - a restart reloads from address 0.
- With `IMEM_LOADER_CLEAR_EN`, memory prefilled with 0xFFFFFFFF, then a 1-word program plus terminator -> words 2..31 read 0. Without the macro, they read 0xFFFFFFFF.
- `start_i` asserted during LOAD -> ignored. `start_i` asserted in DONE -> `cpu_rst_n_o` drops the next cycle and a second program loads correctly.
